// File: rtl/opcode_encoder.sv
// Packs instruction field bundles into 32-bit words behind a 2-entry output FIFO.
// Optional immediate range checking is enabled by defining OPCODE_ENCODER_RANGE_CHECK_EN.
module opcode_encoder (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opcode,
    input  logic [1:0]  in_encoding,
    input  logic [1:0]  in_variant,
    input  logic [5:0]  in_register1,
    input  logic [5:0]  in_register2,
    input  logic [5:0]  in_register3,
    input  logic [31:0] in_immediate,
    input  logic [1:0]  in_operand_size,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_error,
    output logic [15:0] encoded_count
);

    localparam logic [1:0] FMT_A = 2'b00;
    localparam logic [1:0] FMT_B = 2'b01;
    localparam logic [1:0] FMT_C = 2'b10;

    logic [31:0] word_p0;
    logic [1:0]  count_p1;
    logic [31:0] head_word_p1;
    logic [31:0] tail_word_p1;
    logic        push;
    logic        pop;

`ifdef OPCODE_ENCODER_RANGE_CHECK_EN
    logic signed [31:0] imm_s_p0;
    logic               error_p0;
    logic               head_err_p1;
    logic               tail_err_p1;

    function automatic logic fits_unsigned16(input logic [31:0] v);
        return (v[31:16] == 16'd0);
    endfunction

    function automatic logic fits_signed20(input logic signed [31:0] v);
        return (v >= -32'sd524288) && (v <= 32'sd524287);
    endfunction

    function automatic logic fits_signed8(input logic signed [31:0] v);
        return (v >= -32'sd128) && (v <= 32'sd127);
    endfunction

    assign imm_s_p0 = signed'(in_immediate);

    always_comb begin
        error_p0 = 1'b0;
        case (in_encoding)
            FMT_A:   error_p0 = 1'b0;
            FMT_B:   error_p0 = !fits_unsigned16(in_immediate);
            FMT_C:   error_p0 = !fits_signed20(imm_s_p0);
            default: error_p0 = !fits_signed8(imm_s_p0);
        endcase
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_immediate[31:20];
`endif

    // Stage p0: combinational packing of the presented bundle.
    always_comb begin
        word_p0        = 32'd0;
        word_p0[31:30] = in_encoding;
        word_p0[29:24] = in_opcode;
        word_p0[17:16] = in_variant;
        case (in_encoding)
            FMT_A: begin
                word_p0[23:18] = in_register1;
                word_p0[15:14] = in_register3[1:0];
                word_p0[13:8]  = in_register2;
                word_p0[7:6]   = in_operand_size;
                word_p0[3:0]   = in_register3[5:2];
            end
            FMT_B: begin
                word_p0[23:18] = in_register1;
                word_p0[15:8]  = in_immediate[7:0];
                word_p0[7:0]   = in_immediate[15:8];
            end
            FMT_C: begin
                word_p0[23:18] = in_immediate[5:0];
                word_p0[15:8]  = in_immediate[13:6];
                word_p0[7:6]   = in_operand_size;
                word_p0[5:0]   = in_immediate[19:14];
            end
            default: begin
                word_p0[23:18] = in_register1;
                word_p0[15:14] = in_immediate[1:0];
                word_p0[13:8]  = in_register2;
                word_p0[7:6]   = in_operand_size;
                word_p0[5:0]   = in_immediate[7:2];
            end
        endcase
    end

    assign in_ready  = (count_p1 < 2'd2);
    assign out_valid = (count_p1 != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Stage p1: FIFO control, head entry and delivered-word counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_p1      <= 2'd0;
            head_word_p1  <= 32'd0;
            encoded_count <= 16'd0;
        end else begin
            if (pop) begin
                encoded_count <= encoded_count + 16'd1;
            end
            case (count_p1)
                2'd0: begin
                    if (push) begin
                        head_word_p1 <= word_p0;
                        count_p1     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_word_p1 <= word_p0;
                    end else if (push) begin
                        count_p1 <= 2'd2;
                    end else if (pop) begin
                        count_p1 <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_word_p1 <= tail_word_p1;
                        count_p1     <= 2'd1;
                    end
                end
            endcase
        end
    end

    // The tail slot only ever holds data behind a valid head, so it needs no reset.
    always_ff @(posedge Clock) begin
        if (count_p1 == 2'd1 && push && !pop) begin
            tail_word_p1 <= word_p0;
        end
    end

    assign out_word = head_word_p1;

`ifdef OPCODE_ENCODER_RANGE_CHECK_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            head_err_p1 <= 1'b0;
        end else if ((count_p1 == 2'd0 && push) || (count_p1 == 2'd1 && push && pop)) begin
            head_err_p1 <= error_p0;
        end else if (count_p1 == 2'd2 && pop) begin
            head_err_p1 <= tail_err_p1;
        end
    end

    always_ff @(posedge Clock) begin
        if (count_p1 == 2'd1 && push && !pop) begin
            tail_err_p1 <= error_p0;
        end
    end

    assign out_error = head_err_p1;
`else
    assign out_error = 1'b0;
`endif

endmodule

// File: tb/tb_opcode_encoder.sv
// Scoreboard bench for opcode_encoder: expected words queued on acceptance, checked on delivery.
module tb_opcode_encoder;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_opcode = '0;
    logic [1:0]  in_encoding = '0;
    logic [1:0]  in_variant = '0;
    logic [5:0]  in_register1 = '0;
    logic [5:0]  in_register2 = '0;
    logic [5:0]  in_register3 = '0;
    logic [31:0] in_immediate = '0;
    logic [1:0]  in_operand_size = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic        out_error;
    logic [15:0] encoded_count;

    int          vectors = 0;
    int          miscompares = 0;
    logic [32:0] sbq[$];
    logic [15:0] exp_cnt = '0;
    bit          mon_en = 0;

    always #5 Clock = ~Clock;

    opcode_encoder dut (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_encoding(in_encoding), .in_variant(in_variant),
        .in_register1(in_register1), .in_register2(in_register2), .in_register3(in_register3),
        .in_immediate(in_immediate), .in_operand_size(in_operand_size),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_error(out_error), .encoded_count(encoded_count)
    );

    // Reference packing written as whole-word concatenations per format.
    function automatic logic [32:0] model(input logic [1:0] enc, input logic [5:0] op,
                                          input logic [1:0] vr, input logic [5:0] r1,
                                          input logic [5:0] r2, input logic [5:0] r3,
                                          input logic [31:0] imm, input logic [1:0] sz);
        logic [31:0] w;
        logic        e;
        e = 1'b0;
        case (enc)
            2'b00: w = {enc, op, r1, vr, r3[1:0], r2, sz, 2'b00, r3[5:2]};
            2'b01: w = {enc, op, r1, vr, imm[7:0], imm[15:8]};
            2'b10: w = {enc, op, imm[5:0], vr, imm[13:6], sz, imm[19:14]};
            default: w = {enc, op, r1, vr, imm[1:0], r2, sz, imm[7:2]};
        endcase
`ifdef OPCODE_ENCODER_RANGE_CHECK_EN
        case (enc)
            2'b01: e = (imm[31:16] != 16'h0);
            2'b10: e = ($signed(imm) < -524288) || ($signed(imm) > 524287);
            2'b11: e = ($signed(imm) < -128) || ($signed(imm) > 127);
            default: e = 1'b0;
        endcase
`endif
        return {e, w};
    endfunction

    always @(negedge Clock) begin
        if (mon_en) begin
            vectors++;
            if (out_valid !== (sbq.size() != 0)) begin
                miscompares++;
                $display("FAIL out_valid_state: got %b expected %b", out_valid, sbq.size() != 0);
            end
            vectors++;
            if (in_ready !== (sbq.size() < 2)) begin
                miscompares++;
                $display("FAIL in_ready_state: got %b expected %b", in_ready, sbq.size() < 2);
            end
            vectors++;
            if (encoded_count !== exp_cnt) begin
                miscompares++;
                $display("FAIL encoded_count: got %h expected %h", encoded_count, exp_cnt);
            end
            if (Reset) begin
                sbq.delete();
                exp_cnt = '0;
            end else begin
                if (out_valid && out_ready && sbq.size() > 0) begin
                    logic [32:0] exp;
                    exp = sbq.pop_front();
                    vectors++;
                    if ({out_error, out_word} !== exp) begin
                        miscompares++;
                        $display("FAIL output_word: got err=%b word=%h expected err=%b word=%h",
                                 out_error, out_word, exp[32], exp[31:0]);
                    end
                    exp_cnt++;
                end
                if (in_valid && in_ready)
                    sbq.push_back(model(in_encoding, in_opcode, in_variant, in_register1,
                                        in_register2, in_register3, in_immediate, in_operand_size));
            end
        end
    end

    task automatic drive(input logic [1:0] enc, input logic [5:0] op, input logic [1:0] vr,
                         input logic [5:0] r1, input logic [5:0] r2, input logic [5:0] r3,
                         input logic [31:0] imm, input logic [1:0] sz);
        in_encoding = enc; in_opcode = op; in_variant = vr; in_register1 = r1;
        in_register2 = r2; in_register3 = r3; in_immediate = imm; in_operand_size = sz;
    endtask

    task automatic drive_random();
        drive(2'($urandom), 6'($urandom), 2'($urandom), 6'($urandom), 6'($urandom),
              6'($urandom), $urandom, 2'($urandom));
    endtask

    task automatic cycle();
        @(posedge Clock); #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; in_valid = 1'b0;
        cycle(); cycle();
        Reset = 1'b0;
    endtask

    // Presents one bundle, then waits (bounded) for its word at the output.
    task automatic send_and_wait(output logic [31:0] w, output logic e, output bit ok);
        int n;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        ok = 0; n = 0;
        while (!ok && n < 10) begin
            @(negedge Clock);
            if (out_valid) begin ok = 1; w = out_word; e = out_error; end
            n++;
        end
        cycle();
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL wait_output: got timeout expected out_valid within 10 cycles");
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        cycle(); cycle();
        @(negedge Clock);
        mon_en = 1;
        vectors++;
        if ({out_valid, in_ready, out_word, out_error, encoded_count} !== {1'b1 ^ 1'b1, 1'b1, 32'd0, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b r=%b w=%h e=%b c=%h expected v=0 r=1 w=0 e=0 c=0",
                     out_valid, in_ready, out_word, out_error, encoded_count);
        end
        cycle();
        Reset = 1'b0;
    endtask

    task automatic test_formats();
        logic [31:0] w; logic e; bit ok;
        drive(2'b00, 6'h05, 2'd1, 6'd3, 6'd9, 6'h2A, 32'h0, 2'd2);
        send_and_wait(w, e, ok);
        vectors++;
        if (ok && w !== 32'h050D898A) begin
            miscompares++;
            $display("FAIL format_a: got %h expected %h", w, 32'h050D898A);
        end
        drive(2'b01, 6'h10, 2'd0, 6'd1, 6'd0, 6'd0, 32'h0000BEEF, 2'd0);
        send_and_wait(w, e, ok);
        vectors++;
        if (ok && {e, w} !== {1'b0, 32'h5004EFBE}) begin
            miscompares++;
            $display("FAIL format_b: got err=%b word=%h expected err=0 word=5004efbe", e, w);
        end
        drive(2'b10, 6'h3F, 2'd3, 6'd7, 6'd7, 6'd0, 32'hFFF8_1234, 2'd1);
        send_and_wait(w, e, ok);
        vectors++;
        if (ok && w !== {2'b10, 6'h3F, 6'h34, 2'd3, 8'h48, 2'd1, 6'h20}) begin
            miscompares++;
            $display("FAIL format_c: got %h expected %h", w, {2'b10, 6'h3F, 6'h34, 2'd3, 8'h48, 2'd1, 6'h20});
        end
    endtask

    task automatic test_d_range();
        logic [31:0] w; logic e; bit ok; logic exp_e;
`ifdef OPCODE_ENCODER_RANGE_CHECK_EN
        exp_e = 1'b1;
`else
        exp_e = 1'b0;
`endif
        drive(2'b11, 6'h01, 2'd0, 6'd0, 6'd0, 6'd0, 32'h00000180, 2'd0);
        send_and_wait(w, e, ok);
        vectors++;
        if (ok && e !== exp_e) begin
            miscompares++;
            $display("FAIL d_range_error: got %b expected %b", e, exp_e);
        end
        drive(2'b11, 6'h01, 2'd0, 6'd0, 6'd0, 6'd0, 32'hFFFFFF80, 2'd0);
        send_and_wait(w, e, ok);
        vectors++;
        if (ok && {e, w[15:14], w[5:0]} !== {1'b0, 2'b00, 6'h20}) begin
            miscompares++;
            $display("FAIL d_range_ok: got err=%b [15:14]=%b [5:0]=%h expected err=0 00 20", e, w[15:14], w[5:0]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(2'b00, 6'h11, 2'd0, 6'd1, 6'd2, 6'd3, 32'h0, 2'd0);
        cycle();
        drive(2'b01, 6'h22, 2'd1, 6'd4, 6'd0, 6'd0, 32'h0000ABCD, 2'd0);
        cycle();
        drive(2'b11, 6'h33, 2'd2, 6'd5, 6'd6, 6'd0, 32'h7F, 2'd3);
        @(negedge Clock);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_in_ready: got %b expected 0", in_ready);
        end
        held = out_word;
        cycle(); cycle();
        in_valid = 1'b0;
        @(negedge Clock);
        vectors++;
        if (out_word !== held) begin
            miscompares++;
            $display("FAIL stall_hold: got %h expected %h", out_word, held);
        end
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        @(negedge Clock);
        vectors++;
        if (encoded_count !== 16'd2) begin
            miscompares++;
            $display("FAIL drained_count: got %0d expected 2", encoded_count);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_random();
            @(negedge Clock);
            if (i >= 1) begin
                vectors++;
                if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_rate: got v=%b r=%b expected v=1 r=1 at cycle %0d", out_valid, in_ready, i);
                end
            end
            cycle();
        end
        in_valid = 1'b0;
        cycle(); cycle();
    endtask

    task automatic test_random_stall();
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            drive_random();
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        @(negedge Clock);
        vectors++;
        if (sbq.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL random_drain: got queued=%0d v=%b expected 0 0", sbq.size(), out_valid);
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive_random(); cycle();
        drive_random(); cycle();
        drive_random();
        Reset = 1'b1;
        cycle();
        @(negedge Clock);
        vectors++;
        if ({out_valid, in_ready, encoded_count} !== {1'b0, 1'b1, 16'd0}) begin
            miscompares++;
            $display("FAIL reset_mid: got v=%b r=%b c=%h expected v=0 r=1 c=0", out_valid, in_ready, encoded_count);
        end
        cycle();
        Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stale_word: got out_valid=%b word=%h expected out_valid=0", out_valid, out_word);
            end
            cycle();
        end
    endtask

    task automatic test_wrap();
        int xfers;
        bit done;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        xfers = 0; done = 0;
        for (int n = 0; n < 70000 && !done; n++) begin
            drive_random();
            @(negedge Clock);
            if (xfers == 65535) begin
                vectors++;
                if (encoded_count !== 16'hFFFF) begin
                    miscompares++;
                    $display("FAIL count_top: got %h expected ffff", encoded_count);
                end
            end
            if (xfers == 65536) begin
                vectors++;
                if (encoded_count !== 16'h0000) begin
                    miscompares++;
                    $display("FAIL count_wrap: got %h expected 0000", encoded_count);
                end
                done = 1;
            end
            if (out_valid && out_ready) xfers++;
            cycle();
        end
        in_valid = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL wrap_timeout: got %0d transfers expected 65536", xfers);
        end
        cycle(); cycle();
    endtask

    initial begin
        test_reset();
        test_formats();
        test_d_range();
        test_backpressure();
        test_back_to_back();
        test_random_stall();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
